// File: rtl/d_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : d_sram_bridge
// Brief    : Data-cache single-phase port to two-phase sram-like bus bridge.
//            Optional registered response stage: D_BRIDGE_RESP_REG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module d_sram_bridge #(
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] c_addr,
  input  logic [31:0]        c_wdata,
  input  logic               c_strobe,
  input  logic [3:0]         c_wen,
  input  logic [1:0]         c_size,
  input  logic               c_rw,
  output logic [31:0]        c_rdata,
  output logic               c_ready,
  output logic               data_req,
  output logic               data_wr,
  output logic [1:0]         data_size,
  output logic [A_WIDTH-1:0] data_addr,
  output logic [31:0]        data_wdata,
  output logic [3:0]         data_wstrb,
  input  logic [31:0]        data_rdata,
  input  logic               data_addr_ok,
  input  logic               data_data_ok
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_accept;
  logic   w_data_done;

  assign w_accept    = (r_state == IDLE) && c_strobe;
  assign w_data_done = (r_state == DATA) && data_data_ok;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (c_strobe)     w_next = ADDR;
      ADDR: if (data_addr_ok) w_next = DATA;
`ifdef D_BRIDGE_RESP_REG_EN
      DATA: if (data_data_ok) w_next = RESP;
      RESP:                   w_next = IDLE;
`else
      DATA: if (data_data_ok) w_next = IDLE;
`endif
      default:                w_next = IDLE;
    endcase
  end

  // Request fields are captured only at acceptance and held until back in IDLE.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wdata <= 32'd0;
      data_wstrb <= 4'd0;
    end else if (w_accept) begin
      data_req   <= 1'b1;
      data_wr    <= c_rw;
      data_size  <= c_size;
      data_addr  <= c_addr;
      data_wdata <= c_wdata;
      data_wstrb <= c_rw ? c_wen : 4'b0000;
    end else if ((r_state == ADDR) && data_addr_ok) begin
      data_req   <= 1'b0;
    end
  end

`ifdef D_BRIDGE_RESP_REG_EN
  logic [31:0] r_rdata;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)            r_rdata <= 32'd0;
    else if (w_data_done) r_rdata <= data_wr ? 32'd0 : data_rdata;
  end

  assign c_ready = (r_state == RESP);
  assign c_rdata = c_ready ? r_rdata : 32'd0;
`else
  assign c_ready = w_data_done;
  assign c_rdata = (w_data_done && !data_wr) ? data_rdata : 32'd0;
`endif

endmodule
`default_nettype wire
